// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: ALU control codes, controller state encoding and default datapath width.
// Rev 1.0
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_MUL     = 4'b1000;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// alu_mul_iter: shift-add multiplier, one partial product per cycle, WIDTH cycles per product.
// Rev 1.0
module alu_mul_iter import alu_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;
  logic             active;

  // The final step's sum is exposed directly so the caller registers it on the same edge.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = active && (count == LAST);
  assign product  = acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      active <= 1'b0;
    end else if (kill) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      count  <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        count  <= '0;
        active <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_alu_unit.sv
`default_nettype none
// ex_alu_unit: execute-stage ALU with valid/ready handshake and an iterative multiplier.
// Rev 1.0
module ex_alu_unit import alu_pkg::*; #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op,
  output logic             busy
);

  state_t           state;
  logic             accept;
  logic             legal;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] product;

  assign in_ready = (state == ST_IDLE) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_MUL);
  assign is_mul   = legal && (alu_control == ALU_MUL);

  always_comb begin
    alu_res = '0;
    legal   = 1'b1;
    case (alu_control)
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_MUL: legal   = (MUL_EN != 0);
      default: legal   = 1'b0;
    endcase
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .kill    (flush),
        .op_a    (src_a),
        .op_b    (src_b),
        .done    (mul_done),
        .product (product)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign product  = '0;
    end
  endgenerate

  // Flush abandons work but leaves the last result visible on the datapath outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state     <= ST_MUL;
              out_valid <= 1'b0;
            end else begin
              out_valid  <= 1'b1;
              result     <= alu_res;
              zero       <= (alu_res == '0);
              illegal_op <= !legal;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end else if (out_valid) begin
            state <= ST_HOLD;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b1;
            result     <= product;
            zero       <= (product == '0);
            illegal_op <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
